// File: rtl/regfile_rename_ckpt_pkg.sv
// rtl/regfile_rename_ckpt_pkg.sv - shared widths and constants for the rename register file
package regfile_rename_ckpt_pkg;

    localparam int REGFILE_WIDTH = 5;
    localparam int ROB_WIDTH     = 4;
    localparam int CKPT_WIDTH    = 2;

    localparam logic [REGFILE_WIDTH-1:0] ZERO_REGFILE = '0;
    localparam logic [ROB_WIDTH-1:0]     ZERO_ROB     = '0;

    localparam logic BUSY = 1'b1;
    localparam logic FREE = 1'b0;

endpackage

// File: rtl/regfile_rename_ckpt_if.sv
// rtl/regfile_rename_ckpt_if.sv - issue/commit/read bundle between pipeline and register file
interface regfile_rename_ckpt_if #(
    parameter int NREG   = 32,
    parameter int DATA_W = 32,
    parameter int ROB_W  = 4,
    parameter int NREAD  = 2,
    parameter int NCKPT  = 4
);
    localparam int AW = $clog2(NREG);
    localparam int CW = $clog2(NCKPT);

    logic                               flush_in;
    logic                               issue_en_in;
    logic [AW-1:0]                      issue_rd_in;
    logic [ROB_W-1:0]                   issue_tag_in;
    logic                               snap_en_in;
    logic [CW-1:0]                      ckpt_id_out;
    logic                               ckpt_full_out;
    logic                               commit_en_in;
    logic [AW-1:0]                      commit_rd_in;
    logic [ROB_W-1:0]                   commit_tag_in;
    logic [DATA_W-1:0]                  commit_data_in;
    logic                               release_in;
    logic                               restore_en_in;
    logic [CW-1:0]                      restore_id_in;
    logic [NREAD-1:0]                   rd_en_in;
    logic [NREAD-1:0][AW-1:0]           rd_addr_in;
    logic [NREAD-1:0][DATA_W-1:0]       rd_data_out;
    logic [NREAD-1:0]                   rd_rdy_out;
    logic [NREAD-1:0][ROB_W-1:0]        rd_tag_out;

    modport master (
        output flush_in, issue_en_in, issue_rd_in, issue_tag_in, snap_en_in,
        output commit_en_in, commit_rd_in, commit_tag_in, commit_data_in,
        output release_in, restore_en_in, restore_id_in, rd_en_in, rd_addr_in,
        input  ckpt_id_out, ckpt_full_out, rd_data_out, rd_rdy_out, rd_tag_out
    );

    modport slave (
        input  flush_in, issue_en_in, issue_rd_in, issue_tag_in, snap_en_in,
        input  commit_en_in, commit_rd_in, commit_tag_in, commit_data_in,
        input  release_in, restore_en_in, restore_id_in, rd_en_in, rd_addr_in,
        output ckpt_id_out, ckpt_full_out, rd_data_out, rd_rdy_out, rd_tag_out
    );

endinterface

// File: rtl/regfile_rename_ckpt_buf.sv
// rtl/regfile_rename_ckpt_buf.sv - circular buffer of busy/tag map snapshots with commit clearing
module rename_ckpt_buf
    import regfile_rename_ckpt_pkg::*;
#(
    parameter int NREG  = 32,
    parameter int ROB_W = 4,
    parameter int NCKPT = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              rdy_i,
    input  logic                              flush_i,
    input  logic                              commit_en_i,
    input  logic [$clog2(NREG)-1:0]           commit_rd_i,
    input  logic [ROB_W-1:0]                  commit_tag_i,
    input  logic                              push_i,
    input  logic [NREG-1:0]                   push_busy_i,
    input  logic [NREG-1:0][ROB_W-1:0]        push_tag_i,
    input  logic                              release_i,
    input  logic                              restore_en_i,
    input  logic [$clog2(NCKPT)-1:0]          restore_id_i,
    output logic [NREG-1:0]                   restore_busy_o,
    output logic [NREG-1:0][ROB_W-1:0]        restore_tag_o,
    output logic [$clog2(NCKPT)-1:0]          tail_o,
    output logic                              full_o
);
    localparam int CW = $clog2(NCKPT);

    logic [NCKPT-1:0][NREG-1:0]             slot_busy_q, slot_busy_d;
    logic [NCKPT-1:0][NREG-1:0][ROB_W-1:0]  slot_tag_q, slot_tag_d;
    logic [CW-1:0]                          head_q, head_d;
    logic [CW-1:0]                          tail_q, tail_d;
    logic [CW:0]                            count_q, count_d;
    logic [CW-1:0]                          slot_off;
    logic [CW-1:0]                          restore_dist;
    logic                                   pop;

    always_comb begin
        slot_busy_d  = slot_busy_q;
        slot_tag_d   = slot_tag_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        slot_off     = '0;
        restore_dist = restore_id_i - head_q;
        pop          = release_i && (count_q != '0);

        // A retiring producer frees the register in every live snapshot that still waits on it.
        for (int i = 0; i < NCKPT; i++) begin
            slot_off = CW'(i) - head_q;
            if (({1'b0, slot_off} < count_q) && commit_en_i &&
                (slot_tag_q[i][commit_rd_i] == commit_tag_i)) begin
                slot_busy_d[i][commit_rd_i] = FREE;
            end
        end

        if (push_i) begin
            slot_busy_d[tail_q] = push_busy_i;
            slot_tag_d[tail_q]  = push_tag_i;
        end

        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (restore_en_i) begin
            head_d  = head_q + CW'(pop);
            tail_d  = restore_id_i + CW'(1);
            count_d = {1'b0, restore_dist} + (CW+1)'(1) - (CW+1)'(pop);
        end else begin
            head_d  = head_q + CW'(pop);
            tail_d  = tail_q + CW'(push_i);
            count_d = count_q + (CW+1)'(push_i) - (CW+1)'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_busy_q <= '0;
            slot_tag_q  <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
        end else if (rdy_i) begin
            slot_busy_q <= slot_busy_d;
            slot_tag_q  <= slot_tag_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
        end
    end

    assign restore_busy_o = slot_busy_q[restore_id_i];
    assign restore_tag_o  = slot_tag_q[restore_id_i];
    assign tail_o         = tail_q;
    assign full_o         = (count_q == (CW+1)'(NCKPT));

endmodule

// File: rtl/regfile_rename_ckpt.sv
// rtl/regfile_rename_ckpt.sv - architectural register file with rename tags and branch checkpoints
module regfile_rename_ckpt
    import regfile_rename_ckpt_pkg::*;
#(
    parameter int NREG   = 1 << REGFILE_WIDTH,
    parameter int DATA_W = 32,
    parameter int ROB_W  = ROB_WIDTH,
    parameter int NREAD  = 2,
    parameter int NCKPT  = 1 << CKPT_WIDTH
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    regfile_rename_ckpt_if.slave bus
);
    localparam int CW = $clog2(NCKPT);

    logic [DATA_W-1:0]              data_q [NREG];
    logic [NREG-1:0]                busy_q, busy_d, busy_c, busy_i, busy_r;
    logic [NREG-1:0][ROB_W-1:0]     tag_q, tag_d, tag_c, tag_i;
    logic [NREG-1:0]                ckpt_busy;
    logic [NREG-1:0][ROB_W-1:0]     ckpt_tag;
    logic                           commit_wr, issue_wr, snap_push, restore_go, ckpt_full;
    logic [CW-1:0]                  ckpt_tail;
    logic [NREAD-1:0][DATA_W-1:0]   rd_data;
    logic [NREAD-1:0]               rd_rdy;
    logic [NREAD-1:0][ROB_W-1:0]    rd_tag;

    always_comb begin
        commit_wr  = bus.commit_en_in && (bus.commit_rd_in != ZERO_REGFILE);
        issue_wr   = bus.issue_en_in && (bus.issue_rd_in != ZERO_REGFILE);
        restore_go = bus.restore_en_in && !bus.flush_in;
        snap_push  = bus.snap_en_in && !ckpt_full && !bus.flush_in && !bus.restore_en_in;

        busy_c = busy_q;
        tag_c  = tag_q;
        if (commit_wr && (tag_q[bus.commit_rd_in] == bus.commit_tag_in)) begin
            busy_c[bus.commit_rd_in] = FREE;
        end

        // Issue lands after the commit clear so a same-cycle rename of that rd stays busy.
        busy_i = busy_c;
        tag_i  = tag_c;
        if (issue_wr) begin
            busy_i[bus.issue_rd_in] = BUSY;
            tag_i[bus.issue_rd_in]  = bus.issue_tag_in;
        end

        busy_r = ckpt_busy;
        if (commit_wr && (ckpt_tag[bus.commit_rd_in] == bus.commit_tag_in)) begin
            busy_r[bus.commit_rd_in] = FREE;
        end

        if (bus.flush_in) begin
            busy_d = '0;
            tag_d  = tag_c;
        end else if (restore_go) begin
            busy_d = busy_r;
            tag_d  = ckpt_tag;
        end else begin
            busy_d = busy_i;
            tag_d  = tag_i;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q <= '0;
            tag_q  <= '0;
            for (int i = 0; i < NREG; i++) begin
                data_q[i] <= '0;
            end
        end else if (rdy_in) begin
            busy_q <= busy_d;
            tag_q  <= tag_d;
            if (commit_wr) begin
                data_q[bus.commit_rd_in] <= bus.commit_data_in;
            end
        end
    end

    rename_ckpt_buf #(
        .NREG  (NREG),
        .ROB_W (ROB_W),
        .NCKPT (NCKPT)
    ) u_ckpt (
        .clk_i          (clk_in),
        .rst_i          (rst_in),
        .rdy_i          (rdy_in),
        .flush_i        (bus.flush_in),
        .commit_en_i    (commit_wr),
        .commit_rd_i    (bus.commit_rd_in),
        .commit_tag_i   (bus.commit_tag_in),
        .push_i         (snap_push),
        .push_busy_i    (busy_i),
        .push_tag_i     (tag_i),
        .release_i      (bus.release_in),
        .restore_en_i   (restore_go),
        .restore_id_i   (bus.restore_id_in),
        .restore_busy_o (ckpt_busy),
        .restore_tag_o  (ckpt_tag),
        .tail_o         (ckpt_tail),
        .full_o         (ckpt_full)
    );

    // Operand reads bypass a same-cycle commit only when it retires the current producer.
    always_comb begin
        rd_data = '0;
        rd_rdy  = '0;
        rd_tag  = '0;
        for (int p = 0; p < NREAD; p++) begin
            if (!rst_in && !bus.flush_in && bus.rd_en_in[p]) begin
                if (bus.rd_addr_in[p] == ZERO_REGFILE) begin
                    rd_rdy[p] = 1'b1;
                end else if (bus.commit_en_in && (bus.rd_addr_in[p] == bus.commit_rd_in) &&
                             (bus.commit_tag_in == tag_q[bus.rd_addr_in[p]])) begin
                    rd_data[p] = bus.commit_data_in;
                    rd_rdy[p]  = 1'b1;
                    rd_tag[p]  = ZERO_ROB;
                end else begin
                    rd_data[p] = data_q[bus.rd_addr_in[p]];
                    rd_rdy[p]  = !busy_q[bus.rd_addr_in[p]];
                    rd_tag[p]  = tag_q[bus.rd_addr_in[p]];
                end
            end
        end
    end

    assign bus.rd_data_out   = rd_data;
    assign bus.rd_rdy_out    = rd_rdy;
    assign bus.rd_tag_out    = rd_tag;
    assign bus.ckpt_id_out   = ckpt_tail;
    assign bus.ckpt_full_out = ckpt_full;

endmodule

// File: doc/regfile_rename_ckpt.md
# regfile_rename_ckpt

Architectural register file with rename tags and branch checkpoints: holds committed values, a busy bit and ROB tag per register, serves `NREAD` combinational operand reads to issue with same-cycle commit bypass, and keeps up to `NCKPT` in-order snapshots of the busy/tag map. A mispredicted branch restores the map in one cycle instead of a full flush. It sits between issue (reads, renames, snapshots) and commit (writes, releases, restores).

## Interface
- `NREG`, 32: architectural registers; register 0 is hardwired zero
- `DATA_W`, 32: register data width
- `ROB_W`, 4: ROB tag width
- `NREAD`, 2: operand read ports
- `NCKPT`, 4: checkpoint slots (power of two)
- `clk_in` in 1: clock
- `rst_in` in 1: synchronous, active-high reset
- `rdy_in` in 1: global enable; when low, state holds
- `flush_in` in 1: full pipeline flush from commit
- `issue_en_in` in 1, `issue_rd_in` in log2(NREG), `issue_tag_in` in ROB_W: rename rd to tag
- `snap_en_in` in 1: take checkpoint this cycle (branch issued)
- `ckpt_id_out` out log2(NCKPT): slot the next snapshot uses (tail)
- `ckpt_full_out` out 1: no free slot; issue must not snapshot
- `commit_en_in` in 1, `commit_rd_in` in log2(NREG), `commit_tag_in` in ROB_W, `commit_data_in` in DATA_W: retire write
- `release_in` in 1: oldest checkpoint's branch committed; free head
- `restore_en_in` in 1, `restore_id_in` in log2(NCKPT): mispredict; restore slot
- `rd_en_in[NREAD]` in 1, `rd_addr_in[NREAD]` in log2(NREG): read requests
- `rd_data_out[NREAD]` DATA_W, `rd_rdy_out[NREAD]` 1, `rd_tag_out[NREAD]` ROB_W: operand value, valid flag, producer tag

## Operation
- Reset: data, tags, busy all 0; checkpoint head = tail = count = 0; all read outputs 0.
- Commit (rd ≠ 0): data[rd] ← commit_data; busy[rd] cleared only if tag[rd] == commit_tag. Same clear applied to every valid checkpoint whose saved tag[rd] matches.
- Issue (rd ≠ 0): tag[rd] ← issue_tag, busy[rd] set. Issue wins over a same-cycle commit clearing the same rd.
- Snapshot: slot[tail] ← busy/tag map including this cycle's commit and issue; tail+1 mod NCKPT; count+1. Ignored when `ckpt_full_out`.
- Release: head+1, count−1; ignored when count = 0.
- Restore k: live map ← slot[k] with this cycle's commit applied; tail ← k+1; count ← ((k − head) mod NCKPT) + 1 minus any same-cycle release. Slot k itself is kept; all younger slots freed. Same-cycle issue and snapshot ignored.
- Flush: busy cleared, checkpoints emptied (head = tail = count = 0); data write from same-cycle commit still performed.
- Priority: rst > flush > restore > issue/snapshot; commit data write always occurs when enabled and not in reset.
- Read port p: if rst, flush or !rd_en → all 0. Else if addr = 0 → data 0, rdy 1. Else if commit_en, addr == commit_rd, commit_tag == tag[addr] → commit_data, rdy 1, tag 0. Else data[addr], !busy[addr], tag[addr].

## Timing
- Reads combinational, zero latency; all state updates at posedge when `rdy_in`.
- Rename, commit, snapshot and restore visible to reads the cycle after.
- `ckpt_id_out`/`ckpt_full_out` combinational from registered pointers.
- Count range 0..NCKPT; pointer wrap modulo NCKPT; full = count == NCKPT.
- Reset asserted mid-operation clears everything on that edge regardless of other inputs.

## Structure
- Add `REGFILE_WIDTH`, `ROB_WIDTH`, `CKPT_WIDTH`, `ZERO_REGFILE`, `ZERO_ROB`, `BUSY`/`FREE` to the shared defines.
- Sub-module `rename_ckpt_buf`: slot storage, head/tail/count, commit-clear of saved entries, restore read-out.

## Test plan
- Reset, read x5 → data 0, rdy 1, tag 0; read x0 with pending rename → 0, rdy 1.
- Issue x3 tag 7, next cycle read x3 → rdy 0, tag 7; commit x3 tag 7 data 0xDEAD → same cycle rdy 1 data 0xDEAD; commit tag 6 → busy unchanged.
- Issue x4 tag 2 and commit x4 tag 1 same cycle → x4 busy, tag 2.
- Snapshot (slot 0), issue x1 tag 3, x2 tag 4, snapshot (slot 1), issue x1 tag 5; restore 0 → x1, x2 free; count 1; tail 1.
- Snapshot with x6 tag 9 busy, commit x6 tag 9, restore that slot → x6 free.
- Fill 4 slots → full 1, fifth snapshot ignored; release ×4 with wrap → count 0; flush mid-sequence → all busy clear, count 0.
